lif_neuron: RTL

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_neuron.sv | 115 +++++++++++
 1 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: per-synapse weight registers, timestep-driven integration, spike and refractory period.
// Optional leak term enabled by defining LIF_NEURON_LEAK_EN; without it the neuron is pure integrate-and-fire.
module lif_neuron #(
  parameter int N_SYN        = 8,
  parameter int W_WIDTH      = 8,
  parameter int V_WIDTH      = 16,
  parameter int THRESHOLD    = 100,
  parameter int REFRAC_STEPS = 2,
  parameter int LEAK_SHIFT   = 4,
  localparam int AW          = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wt_we_i,
  input  logic [AW-1:0]             wt_addr_i,
  input  logic signed [W_WIDTH-1:0] wt_data_i,
  input  logic [N_SYN-1:0]          axon_i,
  input  logic                      step_i,
  output logic                      spike_o,
  output logic [V_WIDTH-1:0]        potential_o,
  output logic                      refrac_o
);

  localparam int SW  = W_WIDTH + $clog2(N_SYN) + 1;
  localparam int VW2 = V_WIDTH + 2;
  // Evaluation width covers both the potential path and the widest possible synaptic sum.
  localparam int EW  = ((SW > VW2) ? SW : VW2) + 1;
  localparam logic [V_WIDTH-1:0] VMAX = '1;
  localparam logic [V_WIDTH-1:0] THR  = V_WIDTH'(THRESHOLD);
  localparam logic [7:0]         RS   = 8'(REFRAC_STEPS);

  typedef enum logic {ST_INTEGRATE = 1'b0, ST_REFRACTORY = 1'b1} state_t;

  state_t                    r_state;
  logic [7:0]                r_cnt;
  logic                      r_spike;
  logic [V_WIDTH-1:0]        r_pot;
  logic signed [W_WIDTH-1:0] r_wt [N_SYN];

  logic signed [SW-1:0]      w_sum;
  logic [V_WIDTH-1:0]        w_leak;
  logic signed [EW-1:0]      w_vraw;
  logic [V_WIDTH-1:0]        w_vnext;
  logic                      w_fire;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (axon_i[i]) w_sum = w_sum + SW'(r_wt[i]);
    end
  end

`ifdef LIF_NEURON_LEAK_EN
  assign w_leak = r_pot >> LEAK_SHIFT;
`else
  assign w_leak = '0;
`endif

  assign w_vraw = $signed({{(EW-V_WIDTH){1'b0}}, r_pot})
                - $signed({{(EW-V_WIDTH){1'b0}}, w_leak})
                + EW'(w_sum);

  always_comb begin
    if (w_vraw < 0)
      w_vnext = '0;
    else if (w_vraw > $signed({{(EW-V_WIDTH){1'b0}}, VMAX}))
      w_vnext = VMAX;
    else
      w_vnext = w_vraw[V_WIDTH-1:0];
  end

  assign w_fire = (w_vnext >= THR);

  // Weights written this cycle are only visible to the next step (registered before use).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_INTEGRATE;
      r_cnt   <= '0;
      r_spike <= 1'b0;
      r_pot   <= '0;
      for (int i = 0; i < N_SYN; i++) r_wt[i] <= '0;
    end else begin
      r_spike <= 1'b0;
      if (wt_we_i && (int'(wt_addr_i) < N_SYN)) r_wt[wt_addr_i] <= wt_data_i;
      if (step_i) begin
        case (r_state)
          ST_INTEGRATE: begin
            if (w_fire) begin
              r_pot   <= '0;
              // With no refractory period a back-to-back fire is absorbed so pulses never merge.
              r_spike <= ~r_spike;
              if (REFRAC_STEPS > 0) begin
                r_state <= ST_REFRACTORY;
                r_cnt   <= RS;
              end
            end else begin
              r_pot <= w_vnext;
            end
          end
          ST_REFRACTORY: begin
            r_pot <= '0;
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt <= 8'd1) r_state <= ST_INTEGRATE;
          end
          default: r_state <= ST_INTEGRATE;
        endcase
      end
    end
  end

  assign spike_o     = r_spike;
  assign potential_o = r_pot;
  assign refrac_o    = (r_state == ST_REFRACTORY);

endmodule
